// File: rtl/riscv_v_v2i_writeback_if.sv
// Handshake bundle for the v2i writeback block: issue dispatch, result arrival
// from the permutation ALU, and the scalar regfile writeback port.
interface riscv_v_v2i_writeback_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_WIDTH   = 5
);
  logic                  issue_valid;
  logic [RD_WIDTH-1:0]   issue_rd;
  logic                  issue_ready;
  logic                  res_valid;
  logic [RD_WIDTH-1:0]   res_rd;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  wb_valid;
  logic [RD_WIDTH-1:0]   wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_ready;

  modport master (
    output issue_valid, issue_rd, res_valid, res_rd, res_data, wb_ready,
    input  issue_ready, wb_valid, wb_rd, wb_data
  );

  modport slave (
    input  issue_valid, issue_rd, res_valid, res_rd, res_data, wb_ready,
    output issue_ready, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/riscv_v_v2i_writeback.sv
// Scalar return path for vmv.x.s results: in-order result FIFO, issue credit
// counter and pending-rd scoreboard for scalar hazard stalls.
module riscv_v_v2i_writeback #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_WIDTH   = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  riscv_v_v2i_writeback_if.slave     bus,
  output logic [2**RD_WIDTH-1:0]     pending_rd,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       err_overflow
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned EW = RD_WIDTH + DATA_WIDTH;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [EW-1:0]           mem [DEPTH];
  logic [EW-1:0]           head;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count, outstanding_next;
  logic [2**RD_WIDTH-1:0]  set_mask, clr_mask;
  logic full, empty, issue_fire, pop, res_live, push, drop, res_dec;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Head fields are forced to zero when empty so stale storage never leaks out
  assign bus.wb_valid = !empty;
  assign bus.wb_rd    = empty ? '0 : head[EW-1:DATA_WIDTH];
  assign bus.wb_data  = empty ? '0 : head[DATA_WIDTH-1:0];

  assign bus.issue_ready = !flush && (outstanding < FULL_COUNT) && !pending_rd[bus.issue_rd];
  assign issue_fire = bus.issue_valid && bus.issue_ready;
  assign pop        = bus.wb_valid && bus.wb_ready;

  // Results with no outstanding op are ignored, but a full-FIFO arrival still flags overflow
  assign res_live = bus.res_valid && (outstanding != '0);
  assign drop     = bus.res_valid && (bus.res_rd != '0) && full && !pop && !flush;
  assign push     = res_live && (bus.res_rd != '0) && !drop;
  assign res_dec  = res_live && ((bus.res_rd == '0) || drop);

  always_comb begin
    logic [CW:0] up;
    logic [CW:0] dn;
    up = {1'b0, outstanding} + (CW+1)'(issue_fire);
    dn = (CW+1)'(pop) + (CW+1)'(res_dec);
    outstanding_next = (up > dn) ? CW'(up - dn) : '0;
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_fire && (bus.issue_rd != '0)) set_mask[bus.issue_rd] = 1'b1;
    if (pop) clr_mask[bus.wb_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      outstanding  <= '0;
      pending_rd   <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (drop) err_overflow <= 1'b1;
      if (flush) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        count       <= '0;
        outstanding <= '0;
        pending_rd  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count       <= count + CW'(push) - CW'(pop);
        outstanding <= outstanding_next;
        pending_rd  <= (pending_rd | set_mask) & ~clr_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= {bus.res_rd, bus.res_data};
  end
endmodule
